// File: rtl/apb_global_pkg.sv
// Shared APB types for the memory completer.
// Adds completer FSM states and the wait-state limit.
package apb_global_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } tx_type_e;

  typedef enum logic {
    OKAY  = 1'b0,
    ERROR = 1'b1
  } slave_error_e;

  typedef enum logic [2:0] {
    NRM_SEC_DATA   = 3'b000,
    PRV_SEC_DATA   = 3'b001,
    NRM_NSEC_DATA  = 3'b010,
    PRV_NSEC_DATA  = 3'b011,
    NRM_SEC_INSTR  = 3'b100,
    PRV_SEC_INSTR  = 3'b101,
    NRM_NSEC_INSTR = 3'b110,
    PRV_NSEC_INSTR = 3'b111
  } protection_type_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_slv_state_e;

  localparam int unsigned MAX_WAIT_STATES = 15;

endpackage

// File: rtl/apb_slave_mem_responder_if.sv
// APB4 completer-side bus bundle.
// Master drives the request, slave drives the response.
interface apb_slave_mem_responder_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
);

  logic                      pselx;
  logic                      penable;
  logic                      pwrite;
  logic [ADDRESS_WIDTH-1:0]  paddr;
  logic [DATA_WIDTH-1:0]     pwdata;
  logic [DATA_WIDTH/8-1:0]   pstrb;
  logic [2:0]                pprot;
  logic                      pready;
  logic [DATA_WIDTH-1:0]     prdata;
  logic                      pslverr;

  modport master (
    output pselx, penable, pwrite,
    output paddr, pwdata, pstrb, pprot,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  pselx, penable, pwrite,
    input  paddr, pwdata, pstrb, pprot,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/apb_slave_mem_array.sv
// Word storage with per-byte write enables,
// synchronous clear and a combinational read port.
module apb_slave_mem_array #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned DW    = 32,
  parameter int unsigned IW    = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we_i,
  input  logic [IW-1:0]   widx_i,
  input  logic [DW/8-1:0] wstrb_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [IW-1:0]   ridx_i,
  output logic [DW-1:0]   rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int b = 0; b < DW/8; b++) begin
        if (wstrb_i[b]) begin
          mem_q[widx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  assign rdata_o = (32'(ridx_i) < DEPTH) ? mem_q[ridx_i] : '0;

endmodule

// File: rtl/apb_slave_mem_responder.sv
// APB4 memory completer with wait states and range/alignment errors.
// Optional secure-region check: define APB_SLAVE_PROT_CHECK_EN.
module apb_slave_mem_responder
  import apb_global_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MEM_DEPTH     = 64,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                    pclk,
  input  logic                    preset,
  apb_slave_mem_responder_if.slave bus,
  input  logic [3:0]              wait_states_i
);

  localparam int unsigned NB   = DATA_WIDTH / 8;
  localparam int unsigned OFFS = $clog2(NB);
  localparam int unsigned IW   =
    (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned CW   =
    $clog2(MAX_WAIT_STATES + 1);
  localparam int unsigned AW1  = ADDRESS_WIDTH + 1;
  localparam logic [ADDRESS_WIDTH:0] LIMIT =
    {1'b0, BASE_ADDR} + AW1'(MEM_DEPTH * NB);
  localparam logic [ADDRESS_WIDTH-1:0] AMASK =
    ADDRESS_WIDTH'(NB - 1);

  apb_slv_state_e state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           pready_q, pready_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  slave_error_e   pslverr_q, pslverr_d;

  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  tx_type_e                 pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [NB-1:0]            strb_q, strb_d;
  protection_type_e         prot_q, prot_d;

  logic                     is_idle;
  logic [ADDRESS_WIDTH-1:0] a_sel;
  logic [ADDRESS_WIDTH-1:0] off;
  logic [2:0]               p_sel;
  logic                     w_sel;
  logic [IW-1:0]            idx;
  logic                     range_err;
  logic                     align_err;
  logic                     prot_err;
  logic                     err;
  logic [DATA_WIDTH-1:0]    rd_word;
  logic [DATA_WIDTH-1:0]    rd_val;
  logic                     mem_we;

  // Decode from the bus during setup, from latched fields afterwards
  assign is_idle = (state_q == IDLE);
  assign a_sel   = is_idle ? bus.paddr  : addr_q;
  assign p_sel   = is_idle ? bus.pprot  : prot_q;
  assign w_sel   = is_idle ? bus.pwrite : (pwrite_q == WRITE);
  assign off     = a_sel - BASE_ADDR;
  assign idx     = IW'(off >> OFFS);

  assign range_err =
    ({1'b0, a_sel} < {1'b0, BASE_ADDR}) ||
    ({1'b0, a_sel} >= LIMIT);
  assign align_err = |(a_sel & AMASK);

`ifdef APB_SLAVE_PROT_CHECK_EN
  assign prot_err =
    p_sel[1] && (32'(idx) < (MEM_DEPTH / 2));
`else
  logic unused_prot;
  assign unused_prot = ^p_sel;
  assign prot_err    = 1'b0;
`endif

  assign err    = range_err | align_err | prot_err;
  assign rd_val = (err || w_sel) ? '0 : rd_word;

  apb_slave_mem_array #(
    .DEPTH (MEM_DEPTH),
    .DW    (DATA_WIDTH),
    .IW    (IW)
  ) u_mem (
    .clk_i   (pclk),
    .rst_i   (preset),
    .we_i    (mem_we),
    .widx_i  (idx),
    .wstrb_i (strb_q),
    .wdata_i (wdata_q),
    .ridx_i  (idx),
    .rdata_o (rd_word)
  );

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= OKAY;
      addr_q    <= '0;
      pwrite_q  <= READ;
      wdata_q   <= '0;
      strb_q    <= '0;
      prot_q    <= NRM_SEC_DATA;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      addr_q    <= addr_d;
      pwrite_q  <= pwrite_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      prot_q    <= prot_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pready_d  = pready_q;
    prdata_d  = prdata_q;
    pslverr_d = pslverr_q;
    addr_d    = addr_q;
    pwrite_d  = pwrite_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    prot_d    = prot_q;
    mem_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.pselx && !bus.penable) begin
          addr_d   = bus.paddr;
          pwrite_d = bus.pwrite ? WRITE : READ;
          wdata_d  = bus.pwdata;
          strb_d   = bus.pstrb;
          prot_d   = protection_type_e'(bus.pprot);
          cnt_d    = wait_states_i;
          state_d  = ACCESS;
          if (wait_states_i == '0) begin
            pready_d  = 1'b1;
            prdata_d  = rd_val;
            pslverr_d = err ? ERROR : OKAY;
          end
        end
      end
      ACCESS: begin
        if (!bus.pselx) begin
          state_d   = IDLE;
          cnt_d     = '0;
          pready_d  = 1'b0;
          prdata_d  = '0;
          pslverr_d = OKAY;
        end else if (bus.penable) begin
          if (pready_q) begin
            mem_we    = w_sel && !err;
            state_d   = IDLE;
            cnt_d     = '0;
            pready_d  = 1'b0;
            prdata_d  = '0;
            pslverr_d = OKAY;
          end else if (cnt_q > 1) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            cnt_d     = '0;
            pready_d  = 1'b1;
            prdata_d  = rd_val;
            pslverr_d = err ? ERROR : OKAY;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.pready  = pready_q;
  assign bus.prdata  = prdata_q;
  assign bus.pslverr = (pslverr_q == ERROR);

endmodule

// File: tb/tb_apb_slave_mem_responder.sv
// Scoreboard bench for the APB memory completer.
// Driver queues expected responses; a monitor checks them.
module tb_apb_slave_mem_responder;

  logic       pclk = 1'b0;
  logic       preset;
  logic [3:0] ws;

  apb_slave_mem_responder_if #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32)
  ) bus ();

  apb_slave_mem_responder #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .MEM_DEPTH     (64),
    .BASE_ADDR     (32'h0)
  ) dut (
    .pclk          (pclk),
    .preset        (preset),
    .bus           (bus),
    .wait_states_i (ws)
  );

  always #5 pclk = ~pclk;

`ifdef APB_SLAVE_PROT_CHECK_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  typedef struct {
    logic        chk_data;
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(string nm, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
  endtask

  always @(negedge pclk) begin : monitor
    exp_t e;
    if (!preset && bus.pselx && bus.penable &&
        bus.pready) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_pready: got 1 expected 0");
      end else begin
        e = sb.pop_front();
        if (e.chk_data)
          check({e.name, "_prdata"}, bus.prdata, e.rdata);
        check({e.name, "_pslverr"},
              32'(bus.pslverr), 32'(e.err));
      end
    end
  end

  // Entered and left at posedge+1 so calls chain without idle gaps
  task automatic xfer(string nm, bit wr,
                      logic [31:0] a, logic [31:0] d,
                      logic [3:0] st, logic [2:0] pr,
                      logic [3:0] w,
                      logic [31:0] exp_rd, bit exp_err);
    int waits;
    sb.push_back('{chk_data: (!wr || exp_err),
                   rdata: exp_err ? 32'h0 : exp_rd,
                   err: exp_err, name: nm});
    ws          = w;
    bus.pselx   = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = wr;
    bus.paddr   = a;
    bus.pwdata  = d;
    bus.pstrb   = st;
    bus.pprot   = pr;
    @(posedge pclk);
    #1;
    bus.penable = 1'b1;
    ws          = ~w;
    waits       = 0;
    forever begin
      @(negedge pclk);
      if (bus.pready) break;
      waits++;
      if (waits > 40) break;
    end
    check({nm, "_latency"}, 32'(waits), 32'(w));
    @(posedge pclk);
    #1;
    bus.pselx   = 1'b0;
    bus.penable = 1'b0;
  endtask

  task automatic idle_outputs(string nm);
    check({nm, "_pready"},  32'(bus.pready),  32'h0);
    check({nm, "_prdata"},  bus.prdata,       32'h0);
    check({nm, "_pslverr"}, 32'(bus.pslverr), 32'h0);
  endtask

  initial begin
    preset      = 1'b1;
    ws          = '0;
    bus.pselx   = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = '0;
    bus.pwdata  = '0;
    bus.pstrb   = '0;
    bus.pprot   = '0;
    repeat (2) @(posedge pclk);
    #1;
    preset = 1'b0;
    @(negedge pclk);
    idle_outputs("reset");
    @(posedge pclk);
    #1;

    // zero wait, back-to-back
    xfer("w10", 1, 32'h10, 32'hA5A5_1234, 4'hF, 0, 0, 0, 0);
    xfer("r10", 0, 32'h10, 0, 4'hF, 0, 0,
         32'hA5A5_1234, 0);
    xfer("r0_ws3", 0, 32'h0, 0, 4'hF, 0, 3, 0, 0);

    // byte strobes
    xfer("w8_ff", 1, 32'h8, 32'hFFFF_FFFF, 4'hF, 0, 1, 0, 0);
    xfer("w8_st", 1, 32'h8, 32'h1122_3344, 4'b0101, 0, 2,
         0, 0);
    xfer("r8", 0, 32'h8, 0, 4'hF, 0, 0, 32'hFF22_FF44, 0);
    xfer("w8_nostrb", 1, 32'h8, 32'h0, 4'h0, 0, 0, 0, 0);
    xfer("r8_again", 0, 32'h8, 0, 4'h0, 0, 1,
         32'hFF22_FF44, 0);

    // errors and boundaries
    xfer("r100", 0, 32'h100, 0, 4'hF, 0, 0, 0, 1);
    xfer("w3", 1, 32'h3, 32'hDEAD_BEEF, 4'hF, 0, 2, 0, 1);
    xfer("r0_clean", 0, 32'h0, 0, 4'hF, 0, 0, 0, 0);
    xfer("wfc", 1, 32'hFC, 32'h5555_AAAA, 4'hF, 0, 0, 0, 0);
    xfer("rfc", 0, 32'hFC, 0, 4'hF, 0, 15,
         32'h5555_AAAA, 0);
    xfer("rfd", 0, 32'hFD, 0, 4'hF, 0, 0, 0, 1);

    // abort by dropping pselx in access cycle 2
    ws          = 4'd5;
    bus.pselx   = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b1;
    bus.paddr   = 32'h10;
    bus.pwdata  = 32'h0BAD_0BAD;
    bus.pstrb   = 4'hF;
    bus.pprot   = 3'b000;
    @(posedge pclk);
    #1;
    bus.penable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge pclk);
      check("abort_pready", 32'(bus.pready), 32'h0);
    end
    @(posedge pclk);
    #1;
    bus.pselx   = 1'b0;
    bus.penable = 1'b0;
    @(negedge pclk);
    idle_outputs("abort_idle");

    // penable in IDLE without setup is ignored
    @(posedge pclk);
    #1;
    bus.pselx   = 1'b1;
    bus.penable = 1'b1;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    check("noset_pready", 32'(bus.pready), 32'h0);
    @(posedge pclk);
    #1;
    bus.pselx   = 1'b0;
    bus.penable = 1'b0;
    xfer("r10_noabort", 0, 32'h10, 0, 4'hF, 0, 0,
         32'hA5A5_1234, 0);

    // reset while pready and prdata are held
    ws          = 4'd1;
    bus.pselx   = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = 32'h10;
    @(posedge pclk);
    #1;
    bus.penable = 1'b1;
    @(posedge pclk);
    #1;
    preset = 1'b1;
    @(negedge pclk);
    check("pre_rst_prdata", bus.prdata, 32'hA5A5_1234);
    @(posedge pclk);
    #1;
    preset      = 1'b0;
    bus.pselx   = 1'b0;
    bus.penable = 1'b0;
    @(negedge pclk);
    idle_outputs("mid_rst");
    @(posedge pclk);
    #1;
    xfer("r10_cleared", 0, 32'h10, 0, 4'hF, 0, 0, 0, 0);

    // protection: secure lower half, non-secure upper half
    xfer("w0_nsec", 1, 32'h0, 32'h1234_5678, 4'hF,
         3'b010, 0, 0, PROT);
    xfer("r0_prot", 0, 32'h0, 0, 4'hF, 3'b000, 0,
         PROT ? 32'h0 : 32'h1234_5678, 0);
    xfer("w0_sec", 1, 32'h0, 32'hCAFE_F00D, 4'hF,
         3'b000, 0, 0, 0);
    xfer("w80_nsec", 1, 32'h80, 32'h8080_8080, 4'hF,
         3'b010, 1, 0, 0);
    xfer("r80_nsec", 0, 32'h80, 0, 4'hF, 3'b010, 0,
         32'h8080_8080, 0);
    xfer("r0_nsec", 0, 32'h0, 0, 4'hF, 3'b010, 0,
         32'hCAFE_F00D, PROT);

    repeat (2) @(posedge pclk);
    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
